// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the CPU-mapped SPI target (spi_slave_cpu).
package spi_slave_pkg;

  typedef logic [7:0] spi_frame_t;

  localparam int unsigned NumRegs = 4;

  // Register offsets, in units of the bus register stride
  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegPop    = 2'd2;
  localparam logic [1:0] RegLevel  = 2'd3;

  // STATUS bit positions
  localparam int unsigned StRxNotEmpty = 0;
  localparam int unsigned StTxFull     = 1;
  localparam int unsigned StRxOverflow = 2;
  localparam int unsigned StTxUnderrun = 3;
  localparam int unsigned StTxOverflow = 4;
  localparam int unsigned StCsActive   = 5;

  typedef enum logic {
    BitIdle  = 1'b0,
    BitShift = 1'b1
  } bit_state_e;

  // MSB-first shift: new bit enters at the LSB
  function automatic spi_frame_t shift_in(input spi_frame_t cur, input logic b);
    return {cur[6:0], b};
  endfunction

endpackage

// File: rtl/spi_slave_cpu_fifo.sv
// sync_fifo: single-clock FIFO, power-of-two depth, with occupancy count.
// Push on full and pop on empty are ignored; push+pop together keeps the count.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  localparam int unsigned PtrW   = $clog2(Depth),
  localparam int unsigned CountW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              push_i,
  input  logic [Width-1:0]  push_data_i,
  input  logic              pop_i,
  output logic [Width-1:0]  head_c,
  output logic              full_c,
  output logic              empty_c,
  output logic [CountW-1:0] count_o
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (count_o == CountW'(Depth));
  assign empty_c = (count_o == '0);
  assign head_c  = mem[rd_ptr];
  assign do_push = push_i & ~full_c;
  assign do_pop  = pop_i & ~empty_c;

  // Storage write
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data_i;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + CountW'(1);
        2'b01:   count_o <= count_o - CountW'(1);
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: rtl/spi_slave_cpu.sv
// spi_slave_cpu: SPI mode-0 target with CPU-visible RX/TX FIFOs.
// Optional interrupt output enabled by defining SPI_SLAVE_IRQ_EN.
module spi_slave_cpu
  import spi_slave_pkg::*;
#(
  parameter int unsigned             address_width   = 16,
  parameter int unsigned             data_width      = 8,
  parameter logic [address_width-1:0] BaseAddress    = address_width'(32'h9240),
  parameter int unsigned             Address_Wording = 4,
  parameter int unsigned             FifoDepth       = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  input  logic                     rd_wr_i,
  output logic [data_width-1:0]    data_o,
  input  logic                     spi_clk_i,
  input  logic                     spi_cs_ni,
  input  logic                     spi_mosi_i,
  output logic                     spi_miso_o
`ifdef SPI_SLAVE_IRQ_EN
  ,
  output logic                     irq_o
`endif
);

  localparam int unsigned CountW = $clog2(FifoDepth + 1);

  // Synchronizer stages; reset to 0 so a CS held low through reset is not
  // mistaken for a fresh assertion.
  logic sclk_meta, sclk_sync, sclk_prev;
  logic cs_meta, cs_sync, cs_prev;
  logic mosi_meta, mosi_sync;

  logic sclk_rise, sclk_fall, cs_fall, cs_on;

  bit_state_e state, state_next;
  logic [2:0] bit_cnt;
  spi_frame_t rx_shift, rx_next, tx_shift;

  logic frame_clr_c, rx_shift_en_c, byte_done_c, tx_load_c, tx_shift_en_c;

  // FIFO handshakes
  spi_frame_t        rx_head, tx_head;
  logic              rx_full, rx_empty, tx_full, tx_empty;
  logic              rx_push, rx_pop, tx_push, tx_pop;
  logic [CountW-1:0] rx_count, tx_count_unused;

  // CPU decode
  logic [31:0] rel_c;
  logic        hit_c;
  logic [1:0]  reg_idx_c;
  logic        wr_data_c, wr_status_c, wr_pop_c;
  spi_frame_t  status_c, level_c, rd_byte_c;
  logic [31:0] level_wide_c;

  logic rx_ovf, tx_unr, tx_ovf;
  logic rx_ovf_set, tx_unr_set, tx_ovf_set;

  // Pin synchronizers plus one history flop for edge detection
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sclk_meta <= 1'b0; sclk_sync <= 1'b0; sclk_prev <= 1'b0;
      cs_meta   <= 1'b0; cs_sync   <= 1'b0; cs_prev   <= 1'b0;
      mosi_meta <= 1'b0; mosi_sync <= 1'b0;
    end else begin
      sclk_meta <= spi_clk_i;  sclk_sync <= sclk_meta; sclk_prev <= sclk_sync;
      cs_meta   <= spi_cs_ni;  cs_sync   <= cs_meta;   cs_prev   <= cs_sync;
      mosi_meta <= spi_mosi_i; mosi_sync <= mosi_meta;
    end
  end

  assign sclk_rise = sclk_sync & ~sclk_prev;
  assign sclk_fall = ~sclk_sync & sclk_prev;
  assign cs_fall   = cs_prev & ~cs_sync;
  assign cs_on     = ~cs_sync;
  assign rx_next   = shift_in(rx_shift, mosi_sync);

  // Bit FSM state register
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= BitIdle;
    else         state <= state_next;
  end

  // Bit FSM next state: only a fresh CS assertion starts a frame
  always_comb begin
    state_next = state;
    case (state)
      BitIdle:  if (cs_fall) state_next = BitShift;
      BitShift: if (!cs_on)  state_next = BitIdle;
      default:  state_next = BitIdle;
    endcase
  end

  // Bit FSM outputs; the fall right after a byte load must not shift (bit_cnt is 0)
  always_comb begin
    frame_clr_c   = 1'b0;
    rx_shift_en_c = 1'b0;
    byte_done_c   = 1'b0;
    tx_load_c     = 1'b0;
    tx_shift_en_c = 1'b0;
    case (state)
      BitIdle: begin
        frame_clr_c = 1'b1;
        tx_load_c   = cs_fall;
      end
      BitShift: begin
        if (!cs_on) begin
          frame_clr_c = 1'b1;
        end else begin
          if (sclk_rise) begin
            rx_shift_en_c = 1'b1;
            if (bit_cnt == 3'd7) begin
              byte_done_c = 1'b1;
              tx_load_c   = 1'b1;
            end
          end
          if (sclk_fall && (bit_cnt != 3'd0)) tx_shift_en_c = 1'b1;
        end
      end
      default: frame_clr_c = 1'b1;
    endcase
  end

  // Shift registers and bit counter (counter wraps to 0 after the 8th bit)
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bit_cnt  <= 3'd0;
      rx_shift <= '0;
      tx_shift <= '0;
    end else begin
      if (frame_clr_c) begin
        bit_cnt  <= 3'd0;
        rx_shift <= '0;
      end else if (rx_shift_en_c) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= rx_next;
      end
      if (tx_load_c)          tx_shift <= tx_empty ? '0 : tx_head;
      else if (tx_shift_en_c) tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

  assign spi_miso_o = tx_shift[7];

  // Address window decode
  assign rel_c     = 32'(address_i) - 32'(BaseAddress);
  assign hit_c     = (rel_c < 32'(NumRegs * Address_Wording)) &&
                     ((rel_c % 32'(Address_Wording)) == 32'd0);
  assign reg_idx_c = 2'(rel_c / 32'(Address_Wording));

  assign wr_data_c   = rd_wr_i && hit_c && (reg_idx_c == RegData);
  assign wr_status_c = rd_wr_i && hit_c && (reg_idx_c == RegStatus);
  assign wr_pop_c    = rd_wr_i && hit_c && (reg_idx_c == RegPop);

  assign rx_push    = byte_done_c & ~rx_full;
  assign rx_ovf_set = byte_done_c & rx_full;
  assign rx_pop     = wr_pop_c & ~rx_empty;
  assign tx_push    = wr_data_c & ~tx_full;
  assign tx_ovf_set = wr_data_c & tx_full;
  assign tx_pop     = tx_load_c & ~tx_empty;
  assign tx_unr_set = tx_load_c & tx_empty;

  sync_fifo #(.Width(8), .Depth(FifoDepth)) u_rx_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (rx_push),
    .push_data_i (rx_next),
    .pop_i       (rx_pop),
    .head_c      (rx_head),
    .full_c      (rx_full),
    .empty_c     (rx_empty),
    .count_o     (rx_count)
  );

  sync_fifo #(.Width(8), .Depth(FifoDepth)) u_tx_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (tx_push),
    .push_data_i (8'(data_i)),
    .pop_i       (tx_pop),
    .head_c      (tx_head),
    .full_c      (tx_full),
    .empty_c     (tx_empty),
    .count_o     (tx_count_unused)
  );

  // Sticky error flags; a hardware set beats a same-cycle CPU clear
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_ovf <= 1'b0;
      tx_unr <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      rx_ovf <= rx_ovf_set | (rx_ovf & ~(wr_status_c & data_i[StRxOverflow]));
      tx_unr <= tx_unr_set | (tx_unr & ~(wr_status_c & data_i[StTxUnderrun]));
      tx_ovf <= tx_ovf_set | (tx_ovf & ~(wr_status_c & data_i[StTxOverflow]));
    end
  end

  // Read-side register views
  always_comb begin
    status_c               = '0;
    status_c[StRxNotEmpty] = ~rx_empty;
    status_c[StTxFull]     = tx_full;
    status_c[StRxOverflow] = rx_ovf;
    status_c[StTxUnderrun] = tx_unr;
    status_c[StTxOverflow] = tx_ovf;
    status_c[StCsActive]   = (state == BitShift);
    level_wide_c           = 32'(rx_count);
    level_c                = (level_wide_c > 32'd255) ? 8'hFF : 8'(level_wide_c);
  end

  // Read mux; unmapped and write-only offsets return 0
  always_comb begin
    rd_byte_c = '0;
    if (hit_c) begin
      case (reg_idx_c)
        RegData:   rd_byte_c = rx_head;
        RegStatus: rd_byte_c = status_c;
        RegLevel:  rd_byte_c = level_c;
        default:   rd_byte_c = '0;
      endcase
    end
  end

  // Registered read data, one cycle after the address
  always_ff @(posedge clk_i) begin
    if (reset_i) data_o <= '0;
    else         data_o <= data_width'(rd_byte_c);
  end

`ifdef SPI_SLAVE_IRQ_EN
  // Level interrupt: pending RX data or any sticky error
  always_ff @(posedge clk_i) begin
    if (reset_i) irq_o <= 1'b0;
    else         irq_o <= ~rx_empty | rx_ovf | tx_unr | tx_ovf;
  end
`endif

endmodule

// File: tb/tb_spi_slave_cpu.sv
// Directed self-checking bench for spi_slave_cpu.
module tb_spi_slave_cpu;

  localparam logic [15:0] A_DATA = 16'h9240;
  localparam logic [15:0] A_STAT = 16'h9244;
  localparam logic [15:0] A_POP  = 16'h9248;
  localparam logic [15:0] A_LVL  = 16'h924C;
  localparam int HALF = 8;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [15:0] address_i;
  logic [7:0]  data_i;
  logic        rd_wr_i;
  logic [7:0]  data_o;
  logic        spi_clk_i;
  logic        spi_cs_ni;
  logic        spi_mosi_i;
  logic        spi_miso_o;
`ifdef SPI_SLAVE_IRQ_EN
  logic        irq_o;
`endif

  int checks = 0;
  int errors = 0;

  spi_slave_cpu dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .address_i  (address_i),
    .data_i     (data_i),
    .rd_wr_i    (rd_wr_i),
    .data_o     (data_o),
    .spi_clk_i  (spi_clk_i),
    .spi_cs_ni  (spi_cs_ni),
    .spi_mosi_i (spi_mosi_i),
    .spi_miso_o (spi_miso_o)
`ifdef SPI_SLAVE_IRQ_EN
    ,
    .irq_o      (irq_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic ticks(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    address_i = a; data_i = d; rd_wr_i = 1'b1;
    ticks(1);
    rd_wr_i = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    address_i = a; rd_wr_i = 1'b0;
    ticks(1);
    d = data_o;
  endtask

  task automatic cs_assert();
    spi_cs_ni = 1'b0;
    ticks(HALF);
  endtask

  task automatic cs_deassert();
    ticks(HALF);
    spi_cs_ni = 1'b1;
    ticks(HALF);
  endtask

  // Mode 0, MSB first; MISO sampled at the end of each low phase.
  // pop_last issues a CPU POP in the cycle the final rise is acted on.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, input bit pop_last,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi_i = tx[7-i];
      ticks(HALF);
      rx[7-i] = spi_miso_o;
      spi_clk_i = 1'b1;
      if (pop_last && (i == nbits - 1)) begin
        ticks(2);
        address_i = A_POP; rd_wr_i = 1'b1;
        ticks(1);
        rd_wr_i = 1'b0;
        ticks(HALF - 3);
      end else begin
        ticks(HALF);
      end
      spi_clk_i = 1'b0;
    end
  endtask

  logic [7:0] rd, rb;

  initial begin
    reset_i = 1'b1; address_i = '0; data_i = '0; rd_wr_i = 1'b0;
    spi_clk_i = 1'b0; spi_cs_ni = 1'b1; spi_mosi_i = 1'b0;
    ticks(3);
    reset_i = 1'b0;
    chk("reset_data_o", data_o, 8'h00);
    chk("reset_miso", {7'd0, spi_miso_o}, 8'h00);
    cpu_read(A_STAT, rd); chk("reset_status", rd, 8'h00);
    cpu_read(A_LVL, rd);  chk("reset_level", rd, 8'h00);

    // Two-byte exchange in one frame
    cpu_write(A_DATA, 8'hA5);
    cpu_write(A_DATA, 8'h3C);
    cpu_read(A_STAT, rd); chk("t1_status_pre", rd, 8'h00);
    cs_assert();
    cpu_read(A_STAT, rd); chk("t1_status_cs", rd, 8'h20);
    spi_xfer(8'h12, 8, 1'b0, rb); chk("t1_miso0", rb, 8'hA5);
    spi_xfer(8'h34, 8, 1'b0, rb); chk("t1_miso1", rb, 8'h3C);
    cs_deassert();
    cpu_read(A_LVL, rd);  chk("t1_level", rd, 8'h02);
    cpu_read(A_STAT, rd); chk("t1_status", rd, 8'h09);
`ifdef SPI_SLAVE_IRQ_EN
    chk("t1_irq", {7'd0, irq_o}, 8'h01);
`endif
    cpu_read(16'h9241, rd); chk("t1_unaligned", rd, 8'h00);
    cpu_read(16'h9250, rd); chk("t1_unmapped", rd, 8'h00);
    cpu_read(A_DATA, rd); chk("t1_data0", rd, 8'h12);
    cpu_write(A_POP, 8'h00);
    cpu_read(A_DATA, rd); chk("t1_data1", rd, 8'h34);
    cpu_write(A_POP, 8'h00);
    cpu_read(A_LVL, rd);  chk("t1_level_end", rd, 8'h00);
    cpu_write(A_POP, 8'h00);
    cpu_read(A_LVL, rd);  chk("t1_pop_empty", rd, 8'h00);
    cpu_write(A_STAT, 8'h1C);
    cpu_read(A_STAT, rd); chk("t1_clear", rd, 8'h00);

    // RX overflow: 17 bytes into a 16-deep FIFO
    cs_assert();
    for (int i = 0; i < 17; i++) spi_xfer(8'(i + 1), 8, 1'b0, rb);
    cs_deassert();
    cpu_read(A_LVL, rd);  chk("t2_level", rd, 8'd16);
    cpu_read(A_STAT, rd); chk("t2_status", rd, 8'h0D);
    cpu_write(A_STAT, 8'h04);
    cpu_read(A_STAT, rd); chk("t2_clear_ovf", rd, 8'h09);
    for (int i = 0; i < 16; i++) begin
      cpu_read(A_DATA, rd); chk("t2_rx_entry", rd, 8'(i + 1));
      cpu_write(A_POP, 8'h00);
    end
    cpu_read(A_LVL, rd);  chk("t2_level_end", rd, 8'h00);
    cpu_write(A_STAT, 8'h1C);
    cpu_read(A_STAT, rd); chk("t2_clear", rd, 8'h00);

    // TX underrun
    cs_assert();
    spi_xfer(8'h5A, 8, 1'b0, rb); chk("t3_miso", rb, 8'h00);
    cs_deassert();
    cpu_read(A_STAT, rd); chk("t3_status", rd, 8'h09);
    cpu_read(A_DATA, rd); chk("t3_data", rd, 8'h5A);
    cpu_write(A_POP, 8'h00);
    cpu_write(A_STAT, 8'h1C);

    // CS abort after 5 bits, then a full byte
    cs_assert();
    spi_xfer(8'hFF, 5, 1'b0, rb);
    cs_deassert();
    cpu_read(A_LVL, rd);  chk("t4_level_abort", rd, 8'h00);
    cs_assert();
    spi_xfer(8'h81, 8, 1'b0, rb);
    cs_deassert();
    cpu_read(A_LVL, rd);  chk("t4_level", rd, 8'h01);
    cpu_read(A_DATA, rd); chk("t4_data", rd, 8'h81);
    cpu_write(A_POP, 8'h00);
    cpu_write(A_STAT, 8'h1C);

    // POP coinciding with a byte push at LEVEL=3
    cs_assert();
    spi_xfer(8'h11, 8, 1'b0, rb);
    spi_xfer(8'h22, 8, 1'b0, rb);
    spi_xfer(8'h33, 8, 1'b0, rb);
    spi_xfer(8'h44, 8, 1'b1, rb);
    cs_deassert();
    cpu_read(A_LVL, rd);  chk("t5_level", rd, 8'h03);
    cpu_read(A_DATA, rd); chk("t5_head", rd, 8'h22);
    cpu_write(A_POP, 8'h00);
    cpu_read(A_DATA, rd); chk("t5_next", rd, 8'h33);
    cpu_write(A_POP, 8'h00);
    cpu_read(A_DATA, rd); chk("t5_last", rd, 8'h44);
    cpu_write(A_POP, 8'h00);

    // Reset in the middle of a frame
    cpu_write(A_DATA, 8'hC3);
    cs_assert();
    spi_xfer(8'h77, 8, 1'b0, rb);
    spi_xfer(8'hF0, 4, 1'b0, rb);
    reset_i = 1'b1;
    ticks(2);
    reset_i = 1'b0;
    chk("t6_data_o", data_o, 8'h00);
    chk("t6_miso", {7'd0, spi_miso_o}, 8'h00);
    spi_xfer(8'h0F, 4, 1'b0, rb);
    cpu_read(A_LVL, rd);  chk("t6_level", rd, 8'h00);
    cpu_read(A_STAT, rd); chk("t6_status", rd, 8'h00);
    chk("t6_miso_idle", {7'd0, spi_miso_o}, 8'h00);
    cs_deassert();
    cs_assert();
    spi_xfer(8'h55, 8, 1'b0, rb); chk("t6_miso_after", rb, 8'h00);
    cs_deassert();
    cpu_read(A_LVL, rd);  chk("t6_level_after", rd, 8'h01);
    cpu_read(A_DATA, rd); chk("t6_data_after", rd, 8'h55);
    cpu_write(A_POP, 8'h00);
    cpu_write(A_STAT, 8'h1C);

    // TX overflow
    for (int i = 0; i < 17; i++) cpu_write(A_DATA, 8'(i));
    cpu_read(A_STAT, rd); chk("t7_status", rd, 8'h12);
    cpu_write(A_STAT, 8'h10);
    cpu_read(A_STAT, rd); chk("t7_clear", rd, 8'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
